// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: RV32I load/store
// funct3 codes, the controller state type and the request legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

  // A request is legal when its funct3 exists for its direction and the
  // address is naturally aligned for the access size.
  function automatic logic req_legal(input logic       write,
                                     input logic [2:0] funct3,
                                     input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = ~write;
      F3_HU:   ok = ~write & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for word-wide memory: extracts sign/zero-extended load
// data from a word and merges sub-word store data into a word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = word[{lane, 3'b000} +: 8];
  assign sel_half = word[{lane[1], 4'b0000} +: 16];

  // Load extraction: pick the addressed byte/half and extend it.
  always_comb begin
    rdata = word;
    case (funct3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata = {24'b0, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata = {16'b0, sel_half};
      default: rdata = word;
    endcase
  end

  // Store merge: overlay the store data onto the previously read word.
  always_comb begin
    merged = word;
    case (funct3)
      F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the execute stage and a word-wide data memory.
// One request in flight; sub-word stores are done as read-modify-write and
// illegal or misaligned requests complete with an error without touching memory.
//
//  state | meaning
//  IDLE  | ready for a request
//  RD    | memory read of the latched word address (loads, SB/SH)
//  WR    | single-cycle memory write (SW, or merged SB/SH word)
//  RESP  | rsp_valid pulse; result held in rsp_rdata/rsp_error
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter bit MEM_WORD_IDX = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  dmem_state_t           state_q, state_d;
  logic                  lat_write;
  logic [2:0]            lat_f3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           word_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  legal;
  logic [31:0]           align_word;
  logic [31:0]           align_rdata;
  logic [31:0]           align_merged;
  logic [ADDR_WIDTH-1:0] lat_mem_addr;

  assign req_ready = (state_q == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;
  assign legal     = req_legal(req_write, req_funct3, req_addr[1:0]);

  // During RD the live memory word feeds extraction; in WR the sampled word feeds the merge.
  assign align_word = (state_q == RD) ? mem_read_data : word_q;

  dmem_lane_align u_align (
    .word   (align_word),
    .wdata  (lat_wdata),
    .funct3 (lat_f3),
    .lane   (lat_addr[1:0]),
    .rdata  (align_rdata),
    .merged (align_merged)
  );

  assign lat_mem_addr = MEM_WORD_IDX ? {2'b00, lat_addr[ADDR_WIDTH-1:2]}
                                     : {lat_addr[ADDR_WIDTH-1:2], 2'b00};

  assign rsp_valid        = (state_q == RESP);
  assign rsp_rdata        = rdata_q;
  assign rsp_error        = rsp_valid & err_q;
  assign mem_write_enable = (state_q == WR);
  assign mem_addr         = ((state_q == RD) || (state_q == WR)) ? lat_mem_addr : '0;
  assign mem_write_data   = (state_q == WR) ? align_merged : 32'b0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal)                              state_d = RESP;
          else if (req_write && req_funct3 == F3_W) state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD:      state_d = lat_write ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and read-word sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_f3    <= 3'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'b0;
      word_q    <= 32'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state_q == RD) word_q <= mem_read_data;
    end
  end

  // Response registers, loaded on the transition into RESP and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !legal) begin
            rdata_q <= 32'b0;
            err_q   <= 1'b1;
          end
        end
        RD: begin
          if (!lat_write) begin
            rdata_q <= align_rdata;
            err_q   <= 1'b0;
          end
        end
        WR: begin
          rdata_q <= 32'b0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: word-wide data memory model, byte-level
// reference memory, directed and randomized load/store traffic.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int total;
  int bad;

  logic        mem_clr;
  logic [31:0] dmem [64];
  logic [7:0]  ref_mem [256];
  logic [31:0] last_rd;
  logic        last_err;

  dmem_access_ctrl #(.ADDR_WIDTH(32), .MEM_WORD_IDX(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide data memory: combinational read, synchronous write.
  assign mem_read_data = dmem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'b0;
    end else if (mem_write_enable) begin
      dmem[mem_addr[5:0]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_legal(input logic w, input logic [2:0] f3, input int a);
    logic ok;
    int   size;
    if (w) ok = (f3 <= 3'd2);
    else   ok = (f3 <= 3'd5) && (f3 != 3'd3);
    size = 1 << f3[1:0];
    if ((a % size) != 0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    logic [31:0] v;
    logic [15:0] h;
    v = 32'b0;
    case (f3[1:0])
      2'd0: v = f3[2] ? {24'b0, ref_mem[a]} : {{24{ref_mem[a][7]}}, ref_mem[a]};
      2'd1: begin
        h = {ref_mem[a+1], ref_mem[a]};
        v = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endcase
    return v;
  endfunction

  task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    int          a;
    logic        legal;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          exp_we;
    int          got;
    int          we_cnt;
    logic        busy_ok;
    logic [31:0] we_addr;
    logic [31:0] obs_rd;
    logic        obs_err;
    a       = int'(addr);
    legal   = model_legal(w, f3, a);
    exp_lat = !legal ? 1 : ((!w || f3 == 3'd2) ? 2 : 3);
    exp_rd  = (legal && !w) ? model_load(f3, a) : 32'b0;
    exp_we  = (legal && w) ? 1 : 0;

    @(negedge clk);
    check({tag, "_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    got = 0; we_cnt = 0; busy_ok = 1'b1; we_addr = 32'b0; obs_rd = 32'b0; obs_err = 1'b0;
    for (int k = 1; k <= 6 && got == 0; k++) begin
      @(negedge clk);
      if (mem_write_enable) begin
        we_cnt++;
        we_addr = mem_addr;
      end
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        got     = k;
        obs_rd  = rsp_rdata;
        obs_err = rsp_error;
      end
    end
    check({tag, "_latency"}, got, exp_lat);
    check({tag, "_rdata"}, obs_rd, exp_rd);
    check({tag, "_error"}, {31'b0, obs_err}, {31'b0, !legal});
    check({tag, "_we_count"}, we_cnt, exp_we);
    check({tag, "_ready_busy"}, {31'b0, busy_ok}, 32'd1);
    if (exp_we == 1) check({tag, "_we_addr"}, we_addr, addr >> 2);

    if (legal && w) begin
      for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a+i] = wd[8*i +: 8];
    end
    last_rd  = obs_rd;
    last_err = obs_err;
  endtask

  initial begin
    total = 0; bad = 0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
    last_rd = 32'b0; last_err = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    mem_clr = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    check("rst_we", {31'b0, mem_write_enable}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    reset   = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Directed scenarios.
    run_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hF0F0_F0F0);
    run_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10_const", last_rd, 32'hF0F0_F0F0);
    run_req("sw_20", 1'b1, 3'b010, 32'h20, 32'h1122_3344);
    run_req("sb_21", 1'b1, 3'b000, 32'h21, 32'h0000_00AA);
    run_req("lw_20", 1'b0, 3'b010, 32'h20, 32'h0);
    check("lw_20_const", last_rd, 32'h1122_AA44);
    run_req("sh_22", 1'b1, 3'b001, 32'h22, 32'h0000_8001);
    run_req("lh_22", 1'b0, 3'b001, 32'h22, 32'h0);
    check("lh_22_const", last_rd, 32'hFFFF_8001);
    run_req("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0);
    check("lhu_22_const", last_rd, 32'h0000_8001);
    run_req("lb_21", 1'b0, 3'b000, 32'h21, 32'h0);
    check("lb_21_const", last_rd, 32'hFFFF_FFAA);
    run_req("lbu_23", 1'b0, 3'b100, 32'h23, 32'h0);
    check("lbu_23_const", last_rd, 32'h0000_0080);
    run_req("lw_22_mis", 1'b0, 3'b010, 32'h22, 32'h0);
    check("lw_22_err", {31'b0, last_err}, 32'd1);
    run_req("sh_23_mis", 1'b1, 3'b001, 32'h23, 32'hDEAD_BEEF);
    check("sh_23_err", {31'b0, last_err}, 32'd1);
    run_req("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0);
    run_req("st_f3_100", 1'b1, 3'b100, 32'h20, 32'h5555_5555);
    run_req("lw_20_again", 1'b0, 3'b010, 32'h20, 32'h0);
    check("lw_20_unchanged", last_rd, 32'h8001_AA44);

    // Word sweep with alternating patterns.
    for (int wi = 0; wi < 32; wi++) begin
      run_req("sweep_sw_a", 1'b1, 3'b010, 32'(wi * 4), 32'hF0F0_F0F0);
      run_req("sweep_lw_a", 1'b0, 3'b010, 32'(wi * 4), 32'h0);
      run_req("sweep_sw_b", 1'b1, 3'b010, 32'(wi * 4), 32'h0F0F_0F0F);
      run_req("sweep_lw_b", 1'b0, 3'b010, 32'(wi * 4), 32'h0);
    end

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      run_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'($urandom_range(0, 255)), $urandom);
    end

    // Reset while an SB is in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_we_before", {31'b0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we_drop", {31'b0, mem_write_enable}, 32'd0);
    check("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
    begin
      int rsp_seen;
      rsp_seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (rsp_valid === 1'b1) rsp_seen++;
      end
      check("rst_mid_no_rsp", rsp_seen, 0);
    end
    run_req("lb_31_after_rst", 1'b0, 3'b100, 32'h31, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
